instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 25 ++
 rtl/instr_encoder.sv | 103 ++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bus of the MIPS instruction encoder: encode requests in,
// encoded 32-bit words out, each with its own valid/ready handshake.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;

   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_instr
   );

   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      output in_ready, out_valid, out_instr
   );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding a 4-deep output FIFO, with a pop counter.
// Optional macro ENC_ILLEGAL_ERR_EN: illegal ops are dropped and raise a sticky err.
module instr_encoder (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   instr_encoder_if.slave bus,
   output logic [15:0]   issued,
   output logic          err
);
   logic [31:0] r_mem [4];
   logic [1:0]  r_wptr;
   logic [1:0]  r_rptr;
   logic [2:0]  r_count;
   logic [15:0] r_issued;

   logic        w_accept;
   logic        w_pop;
   logic        w_push;
   logic [31:0] w_word;

   // Fields an op does not use are left at zero by construction.
   always_comb begin
      w_word = 32'h0;
      case (bus.in_op)
         4'd1: w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100000};
         4'd2: w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100010};
         4'd3: w_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd4: w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd5: w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd6: w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd7: w_word = {6'b001111, 5'b00000, bus.in_rt, bus.in_imm};
         4'd8: w_word = {6'b000011, bus.in_target};
         4'd9: w_word = {6'b000000, bus.in_rs, 15'b0, 6'b001000};
         default: w_word = 32'h0;
      endcase
   end

   // No bypass: a full queue refuses even when a pop happens this cycle.
   assign bus.in_ready  = (r_count < 3'd4);
   assign bus.out_valid = (r_count != 3'd0);
   assign bus.out_instr = bus.out_valid ? r_mem[r_rptr] : 32'h0;
   assign issued        = r_issued;

   assign w_accept = bus.in_valid & bus.in_ready;
   assign w_pop    = bus.out_valid & bus.out_ready;

`ifdef ENC_ILLEGAL_ERR_EN
   logic r_err;
   logic w_illegal;

   assign w_illegal = (bus.in_op > 4'd9);
   assign w_push    = w_accept & ~w_illegal;
   assign err       = r_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (flush) begin
         r_err <= 1'b0;
      end else if (w_accept && w_illegal) begin
         r_err <= 1'b1;
      end
   end
`else
   assign w_push = w_accept;
   assign err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr   <= 2'd0;
         r_rptr   <= 2'd0;
         r_count  <= 3'd0;
         r_issued <= 16'd0;
      end else if (flush) begin
         r_wptr   <= 2'd0;
         r_rptr   <= 2'd0;
         r_count  <= 3'd0;
         r_issued <= 16'd0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 2'd1;
         end
         if (w_pop) begin
            r_rptr   <= r_rptr + 2'd1;
            r_issued <= r_issued + 16'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the pointers and occupancy decide what is visible.
   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_mem[r_wptr] <= w_word;
      end
   end
endmodule
